// File: rtl/clint_ctrl.sv
// clint_ctrl: core-local interruptor with 64-bit mtime, per-hart mtimecmp and msip.
// Ports: CLK/RST (async, active-high); bus slave addr/wdata/byte_en/ren/wen -> rdata/busy;
//        soft_int/timer_int and their 1-cycle falling-edge clear strobes per hart.
// Optional macro CLINT_PRESCALER_EN: mtime ticks once every PRESCALE cycles instead of every cycle.
module clint_ctrl #(
    parameter int NUM_HARTS = 1,
    parameter int PRESCALE  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           byte_en,
    input  logic                 ren,
    input  logic                 wen,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic [NUM_HARTS-1:0] soft_int,
    output logic [NUM_HARTS-1:0] timer_int,
    output logic [NUM_HARTS-1:0] soft_int_clear,
    output logic [NUM_HARTS-1:0] timer_int_clear
);

    localparam logic [15:0] CMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO = 16'hBFF8;
    localparam logic [15:0] MTIME_HI = 16'hBFFC;

    typedef enum logic {IDLE, RESP} state_t;

    state_t state, state_nxt;

    logic [15:0]          off_q;
    logic                 rd_q;
    logic [63:0]          mtime, mtime_nxt;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic [NUM_HARTS-1:0] soft_prev, timer_prev;

    logic                 req, accept, do_wr;
    logic [NUM_HARTS-1:0] wr_msip, wr_cmp_lo, wr_cmp_hi;
    logic                 wr_mt_lo, wr_mt_hi;
    logic                 tick;
    logic [31:0]          rd_val;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:16];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign req    = ren | wen;
    assign accept = (state == IDLE) && req;
    // ren&wen together is a write
    assign do_wr  = accept && wen;

    // Write decode uses the live address: the commit happens on the accept edge
    always_comb begin
        wr_msip   = '0;
        wr_cmp_lo = '0;
        wr_cmp_hi = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            wr_msip[h]   = do_wr && (addr[15:0] == 16'(4 * h));
            wr_cmp_lo[h] = do_wr && (addr[15:0] == CMP_BASE + 16'(8 * h));
            wr_cmp_hi[h] = do_wr && (addr[15:0] == CMP_BASE + 16'(8 * h + 4));
        end
        wr_mt_lo = do_wr && (addr[15:0] == MTIME_LO);
        wr_mt_hi = do_wr && (addr[15:0] == MTIME_HI);
    end

`ifdef CLINT_PRESCALER_EN
    logic [31:0] pre_cnt;

    assign tick = (pre_cnt == 32'(PRESCALE - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pre_cnt <= '0;
        else if (wr_mt_lo || wr_mt_hi || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 32'd1;
    end
`else
    localparam int unused_prescale = PRESCALE;

    assign tick = 1'b1;
`endif

    // A bus write to either half swallows that cycle's tick entirely
    always_comb begin
        mtime_nxt = mtime;
        if (wr_mt_lo || wr_mt_hi) begin
            if (wr_mt_lo)
                mtime_nxt[31:0] = merge(mtime[31:0], wdata, byte_en);
            if (wr_mt_hi)
                mtime_nxt[63:32] = merge(mtime[63:32], wdata, byte_en);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mtime <= '0;
            msip  <= '0;
            for (int h = 0; h < NUM_HARTS; h++)
                mtimecmp[h] <= '1;
        end else begin
            mtime <= mtime_nxt;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr_msip[h] && byte_en[0])
                    msip[h] <= wdata[0];
                if (wr_cmp_lo[h])
                    mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata, byte_en);
                if (wr_cmp_hi[h])
                    mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata, byte_en);
            end
        end
    end

    assign soft_int = msip;

    // Clear strobes fire one cycle after the int output has already dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_int       <= '0;
            timer_prev      <= '0;
            soft_prev       <= '0;
            timer_int_clear <= '0;
            soft_int_clear  <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++)
                timer_int[h] <= (mtime >= mtimecmp[h]);
            timer_prev      <= timer_int;
            soft_prev       <= soft_int;
            timer_int_clear <= timer_prev & ~timer_int;
            soft_int_clear  <= soft_prev & ~soft_int;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            off_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q <= addr[15:0];
                rd_q  <= ren & ~wen;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        unique case (state)
            IDLE: if (req) state_nxt = RESP;
            RESP: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (off_q == 16'(4 * h))
                rd_val = {31'b0, msip[h]};
            if (off_q == CMP_BASE + 16'(8 * h))
                rd_val = mtimecmp[h][31:0];
            if (off_q == CMP_BASE + 16'(8 * h + 4))
                rd_val = mtimecmp[h][63:32];
        end
        if (off_q == MTIME_LO)
            rd_val = mtime[31:0];
        if (off_q == MTIME_HI)
            rd_val = mtime[63:32];
    end

    assign rdata = (state == RESP && rd_q) ? rd_val : 32'd0;

endmodule
